// File: rtl/cmd_exec_fsm.sv
// Command-list executor: walks a command buffer from address 0, issuing bus
// writes and read-modify-writes until an all-zero entry, the address limit, or a fault.
module cmd_exec_fsm #(
  parameter int                    CMD_WIDTH  = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 32'h0000_04A0,
  parameter int                    TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic                  cmd_rd_en,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_rd_valid,
  input  logic [CMD_WIDTH-1:0]  cmd_out,
  output logic                  mst_o_valid,
  output logic [ADDR_WIDTH-1:0] mst_o_addr,
  output logic [DATA_WIDTH-1:0] mst_o_wr_data,
  output logic                  mst_o_rd0_wr1,
  input  logic                  mst_i_ready,
  input  logic                  mst_i_rd_valid,
  input  logic [DATA_WIDTH-1:0] mst_i_rd_data
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_WAIT_CMD  = 4'd2;
  localparam logic [3:0] S_DECODE    = 4'd3;
  localparam logic [3:0] S_WR_REQ    = 4'd4;
  localparam logic [3:0] S_RD_REQ    = 4'd5;
  localparam logic [3:0] S_RD_WAIT   = 4'd6;
  localparam logic [3:0] S_FETCH2    = 4'd7;
  localparam logic [3:0] S_WAIT_CMD2 = 4'd8;
  localparam logic [3:0] S_MERGE_REQ = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;
  localparam logic [3:0] S_ERR       = 4'd11;

  localparam logic [1:0] T_WRITE = 2'b00;
  localparam logic [1:0] T_RWM   = 2'b01;

  localparam int             TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  error_q, error_d;
  logic [1:0]            code_q, code_d;

  logic [ADDR_WIDTH-1:0] q_addr, in_addr;
  logic [DATA_WIDTH-1:0] q_data, in_data;
  logic [1:0]            q_type, in_type;
  logic                  at_end, tmo_hit;

  always_comb begin
    q_addr  = {cmd_q[CMD_WIDTH-1 -: ADDR_WIDTH-2], 2'b00};
    q_data  = cmd_q[DATA_WIDTH+1:2];
    q_type  = cmd_q[1:0];
    in_addr = {cmd_out[CMD_WIDTH-1 -: ADDR_WIDTH-2], 2'b00};
    in_data = cmd_out[DATA_WIDTH+1:2];
    in_type = cmd_out[1:0];
    at_end  = (ptr_q >= END_ADDR);
    tmo_hit = (tmo_q == TMO_LAST);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    cmd_d   = cmd_q;
    tmo_d   = '0;
    error_d = error_q;
    code_d  = code_q;

    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        ptr_d   = '0;
        error_d = 1'b0;
        code_d  = 2'b00;
      end
      S_FETCH: state_d = at_end ? S_DONE : S_WAIT_CMD;
      S_WAIT_CMD: if (cmd_rd_valid) begin
        if (cmd_out == '0) state_d = S_DONE;
        else begin
          cmd_d   = cmd_out;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        addr_d = q_addr;
        if (q_type == T_WRITE) begin
          wdata_d = q_data;
          state_d = S_WR_REQ;
        end else if (q_type == T_RWM) begin
          mask_d  = q_data;
          state_d = S_RD_REQ;
        end else begin
          error_d = 1'b1;
          code_d  = 2'b01;
          state_d = S_ERR;
        end
      end
      // Request states share one handshake/timeout shape; only the successor differs.
      S_WR_REQ, S_MERGE_REQ, S_RD_REQ: begin
        if (mst_i_ready) begin
          if (state_q == S_RD_REQ) state_d = S_RD_WAIT;
          else begin
            ptr_d   = ptr_q + STEP;
            state_d = S_FETCH;
          end
        end else if (tmo_hit) begin
          error_d = 1'b1;
          code_d  = 2'b11;
          state_d = S_ERR;
        end else tmo_d = tmo_q + 1'b1;
      end
      S_RD_WAIT: begin
        if (mst_i_rd_valid) begin
          rdata_d = mst_i_rd_data;
          ptr_d   = ptr_q + STEP;
          state_d = S_FETCH2;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          code_d  = 2'b11;
          state_d = S_ERR;
        end else tmo_d = tmo_q + 1'b1;
      end
      S_FETCH2: begin
        if (at_end) begin
          error_d = 1'b1;
          code_d  = 2'b10;
          state_d = S_ERR;
        end else state_d = S_WAIT_CMD2;
      end
      S_WAIT_CMD2: if (cmd_rd_valid) begin
        if (in_type == T_WRITE) begin
          addr_d  = in_addr;
          wdata_d = (rdata_q & ~mask_q) | (in_data & mask_q);
          state_d = S_MERGE_REQ;
        end else begin
          error_d = 1'b1;
          code_d  = 2'b10;
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      cmd_q   <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      cmd_q   <= cmd_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    error         = error_q;
    err_code      = code_q;
    cmd_rd_en     = ((state_q == S_FETCH) || (state_q == S_FETCH2)) && !at_end;
    cmd_addr      = ptr_q;
    mst_o_valid   = (state_q == S_WR_REQ) || (state_q == S_RD_REQ) || (state_q == S_MERGE_REQ);
    mst_o_rd0_wr1 = (state_q == S_WR_REQ) || (state_q == S_MERGE_REQ);
    mst_o_addr    = addr_q;
    mst_o_wr_data = wdata_q;
  end

endmodule

// File: tb/tb_cmd_exec_fsm.sv
// Directed bench for cmd_exec_fsm: table of command lists plus hand sequences
// for bus stall, timeout, and reset during a pending read.
module tb_cmd_exec_fsm;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic        cmd_rd_en, cmd_rd_valid;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_out;
  logic        mst_o_valid, mst_o_rd0_wr1, mst_i_ready, mst_i_rd_valid;
  logic [31:0] mst_o_addr, mst_o_wr_data, mst_i_rd_data;

  cmd_exec_fsm #(.END_ADDR(32'h0000_0010)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .cmd_rd_en(cmd_rd_en), .cmd_addr(cmd_addr),
    .cmd_rd_valid(cmd_rd_valid), .cmd_out(cmd_out), .mst_o_valid(mst_o_valid),
    .mst_o_addr(mst_o_addr), .mst_o_wr_data(mst_o_wr_data), .mst_o_rd0_wr1(mst_o_rd0_wr1),
    .mst_i_ready(mst_i_ready), .mst_i_rd_valid(mst_i_rd_valid), .mst_i_rd_data(mst_i_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] e0, e1, e2, e3;
    logic [31:0] rdata;
    int          delay;
    int          nw;
    logic [31:0] a0, d0, a1, d1;
    int          nreq;
    int          nf;
    logic        err;
    logic [1:0]  code;
    int          ndone;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] mem[16];
  logic [31:0] flog[8], wa[8], wd[8];
  logic [31:0] caddr, ha, hd, rdata;
  int          nf, nw, nreq, nvc, stab_err, ndone, delay, stall;
  bit          never_ready, no_rdata, cpend, rpend;
  int          ntests = 0, nfail = 0;

  function automatic logic [63:0] mk(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    return {a[31:2], d, t};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    nf = 0; nw = 0; nreq = 0; nvc = 0; stab_err = 0; ndone = 0;
    delay = 0; stall = 0; never_ready = 0; no_rdata = 0; rpend = 0; rdata = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
  endtask

  task automatic run(input int maxcyc, input string name);
    int cyc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (busy && cyc < maxcyc) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_finished"}, busy, 1'b0);
  endtask

  // Command buffer and bus slave models, driven on the falling edge.
  initial begin
    cmd_rd_valid = 0; cmd_out = '0; mst_i_ready = 0; mst_i_rd_valid = 0; mst_i_rd_data = '0;
    cpend = 0; rpend = 0; caddr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmd_rd_valid = 0; mst_i_ready = 0; mst_i_rd_valid = 0;
        cpend = 0; rpend = 0; stall = 0;
      end else begin
        if (done) ndone++;
        cmd_rd_valid = cpend;
        cmd_out      = cpend ? mem[caddr[5:2]] : '0;
        cpend        = cmd_rd_en;
        if (cmd_rd_en) begin
          caddr = cmd_addr;
          if (nf < 8) flog[nf] = cmd_addr;
          nf++;
        end
        mst_i_rd_valid = rpend && !no_rdata;
        mst_i_rd_data  = rdata;
        if (mst_i_rd_valid) rpend = 0;
        mst_i_ready = 0;
        if (mst_o_valid) begin
          nvc++;
          if (stall == 0) begin ha = mst_o_addr; hd = mst_o_wr_data; end
          else if (ha !== mst_o_addr || (mst_o_rd0_wr1 && hd !== mst_o_wr_data)) stab_err++;
          if (!never_ready && stall >= delay) begin
            mst_i_ready = 1;
            nreq++;
            stall = 0;
            if (mst_o_rd0_wr1) begin
              if (nw < 8) begin wa[nw] = mst_o_addr; wd[nw] = mst_o_wr_data; end
              nw++;
            end else rpend = 1;
          end else stall++;
        end
      end
    end
  end

  initial begin
    vecs[0] = '{mk(32'h1000, 32'hA5A5A5A5, 2'b00), mk(32'h1004, 32'h1, 2'b00), 64'h0, 64'h0,
                32'h0, 0, 2, 32'h1000, 32'hA5A5A5A5, 32'h1004, 32'h1, 2, 3, 1'b0, 2'b00, 1};
    vecs[1] = '{mk(32'h2000, 32'h0000FF00, 2'b01), mk(32'h2000, 32'h00001200, 2'b00), 64'h0, 64'h0,
                32'hDEADBEEF, 0, 1, 32'h2000, 32'hDEAD12EF, 32'h0, 32'h0, 2, 3, 1'b0, 2'b00, 1};
    vecs[2] = '{mk(32'h1000, 32'h0, 2'b11), 64'h0, 64'h0, 64'h0,
                32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 1'b1, 2'b01, 0};
    vecs[3] = '{mk(32'h3000, 32'h000000FF, 2'b01), mk(32'h3000, 32'h5, 2'b01), 64'h0, 64'h0,
                32'h12345678, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 2, 1'b1, 2'b10, 0};
    vecs[4] = '{mk(32'h10, 32'h1, 2'b00), mk(32'h14, 32'h2, 2'b00), mk(32'h18, 32'h3, 2'b00),
                mk(32'h1C, 32'h4, 2'b00),
                32'h0, 0, 4, 32'h10, 32'h1, 32'h14, 32'h2, 4, 4, 1'b0, 2'b00, 1};
    vecs[5] = '{mk(32'h100, 32'h1, 2'b00), mk(32'h104, 32'h2, 2'b00), mk(32'h108, 32'h3, 2'b00),
                mk(32'h40, 32'hF, 2'b01),
                32'h0, 0, 3, 32'h100, 32'h1, 32'h104, 32'h2, 4, 4, 1'b1, 2'b10, 0};
    vecs[6] = '{mk(32'h50, 32'h7, 2'b00), mk(32'h0, 32'h0, 2'b10), 64'h0, 64'h0,
                32'h0, 0, 1, 32'h50, 32'h7, 32'h0, 32'h0, 1, 2, 1'b1, 2'b01, 0};
    vecs[7] = '{mk(32'h2000, 32'h0000FF00, 2'b01), mk(32'h2000, 32'h00001200, 2'b00), 64'h0, 64'h0,
                32'hDEADBEEF, 3, 1, 32'h2000, 32'hDEAD12EF, 32'h0, 32'h0, 2, 3, 1'b0, 2'b00, 1};

    rst_n = 1'b0; start = 1'b0;
    clear_model();
    #3;
    chk("reset_outputs",
        {busy, done, error, err_code, cmd_rd_en, cmd_addr, mst_o_valid, mst_o_addr, mst_o_wr_data, mst_o_rd0_wr1},
        '0);
    #20 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      clear_model();
      mem[0] = vecs[i].e0; mem[1] = vecs[i].e1; mem[2] = vecs[i].e2; mem[3] = vecs[i].e3;
      rdata = vecs[i].rdata;
      delay = vecs[i].delay;
      run(2000, $sformatf("v%0d", i));
      chk($sformatf("v%0d_nwrites", i), nw, vecs[i].nw);
      chk($sformatf("v%0d_nreq", i), nreq, vecs[i].nreq);
      chk($sformatf("v%0d_nfetch", i), nf, vecs[i].nf);
      chk($sformatf("v%0d_error", i), error, vecs[i].err);
      chk($sformatf("v%0d_err_code", i), err_code, vecs[i].code);
      chk($sformatf("v%0d_done_pulses", i), ndone, vecs[i].ndone);
      chk($sformatf("v%0d_stable", i), stab_err, 0);
      if (vecs[i].nw > 0) chk($sformatf("v%0d_w0", i), {wa[0], wd[0]}, {vecs[i].a0, vecs[i].d0});
      if (vecs[i].nw > 1) chk($sformatf("v%0d_w1", i), {wa[1], wd[1]}, {vecs[i].a1, vecs[i].d1});
      for (int k = 0; k < vecs[i].nf && k < 8; k++)
        chk($sformatf("v%0d_cmd_addr%0d", i, k), flog[k], 32'(4 * k));
    end

    // Write held off for five cycles: one transfer over six valid cycles.
    clear_model();
    mem[0] = mk(32'h1000, 32'hCAFE0001, 2'b00);
    delay = 5;
    run(200, "stall");
    chk("stall_valid_cycles", nvc, 6);
    chk("stall_nwrites", nw, 1);
    chk("stall_stable", stab_err, 0);
    chk("stall_w0", {wa[0], wd[0]}, {32'h1000, 32'hCAFE0001});

    // Bus never accepts: timeout fault.
    clear_model();
    mem[0] = mk(32'h1000, 32'h1, 2'b00);
    never_ready = 1;
    run(600, "tmo");
    chk("tmo_valid_cycles", nvc, 256);
    chk("tmo_error", error, 1'b1);
    chk("tmo_err_code", err_code, 2'b11);
    chk("tmo_valid_dropped", mst_o_valid, 1'b0);
    chk("tmo_done_pulses", ndone, 0);

    // Reset while the read data is outstanding, then a clean rerun.
    clear_model();
    mem[0] = mk(32'h2000, 32'h000000FF, 2'b01);
    mem[1] = mk(32'h2000, 32'h1, 2'b00);
    no_rdata = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int w = 0; w < 50 && nreq < 1; w++) @(negedge clk);
    chk("rdwait_reached", nreq, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rdwait_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {busy, done, error, err_code, cmd_rd_en, cmd_addr, mst_o_valid, mst_o_addr, mst_o_wr_data, mst_o_rd0_wr1},
        '0);
    @(negedge clk);
    clear_model();
    rst_n = 1'b1;
    mem[0] = vecs[0].e0; mem[1] = vecs[0].e1;
    run(500, "rerun");
    chk("rerun_first_addr", flog[0], 32'h0);
    chk("rerun_nwrites", nw, 2);
    chk("rerun_error", error, 1'b0);
    chk("rerun_done_pulses", ndone, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
